// File: rtl/qspi_pkg.sv
// Shared definitions for the quad-SPI ROM read arbiter: the state encoding,
// the default read opcode and the nibble counts of the fixed-length phases.
package qspi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CMD      = 3'd1,
    ST_ADDR     = 3'd2,
    ST_DUMMY    = 3'd3,
    ST_DATA     = 3'd4,
    ST_DESELECT = 3'd5
  } qspi_state_e;

  localparam logic [7:0] QSPI_CMD_DEFAULT = 8'hEB;
  localparam int         CMD_NIBBLES      = 2;
  localparam int         DATA_NIBBLES     = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/qspi_nibble_shifter.sv
// Parallel-load shift register moving one nibble per step, MSB first. It
// streams {opcode, address} out and collects the returned data nibbles.
module qspi_nibble_shifter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         shift_i,
  input  logic [3:0]   nib_i,
  output logic [3:0]   msb_nib_o,
  output logic [3:0]   lsb_nib_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= load_val_i;
    end else if (shift_i) begin
      data_q <= {data_q[W-5:0], nib_i};
    end
  end

  assign msb_nib_o = data_q[W-1:W-4];
  assign lsb_nib_o = data_q[3:0];

endmodule

// File: rtl/qspi_rom_arbiter.sv
// Two-requester fixed-priority arbiter in front of a quad-SPI flash: each grant
// runs one CMD/ADDR/DUMMY/DATA frame and returns a single byte to the grantee.
module qspi_rom_arbiter
  import qspi_pkg::*;
#(
  parameter int         ADDR_W        = 24,
  parameter int         DUMMY_NIBBLES = 4,
  parameter logic [7:0] CMD           = QSPI_CMD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack1,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic              spi_sck,
  output logic              spi_cs_n,
  output logic [3:0]        spi_io_out,
  output logic [3:0]        spi_io_oe,
  input  logic [3:0]        spi_io_in,
  output qspi_state_e       dbg_state_o
);

  localparam int ADDR_NIBBLES = ADDR_W / 4;
  localparam int MAX_NIB      = max_int(max_int(CMD_NIBBLES, DATA_NIBBLES),
                                        max_int(ADDR_NIBBLES, DUMMY_NIBBLES));
  localparam int CNT_W        = (MAX_NIB > 1) ? $clog2(MAX_NIB) : 1;
  localparam int SH_W         = 8 + ADDR_W;

  qspi_state_e       state_q;
  logic              ph_q;        // 0: SCK low, new nibble driven; 1: SCK high
  logic [CNT_W-1:0]  cnt_q;
  logic              grant1_q;
  logic              cs_n_q;
  logic              sck_q;
  logic [3:0]        oe_q;
  logic              ack0_q;
  logic              ack1_q;
  logic [7:0]        rdata_q;

  logic              start_d;
  logic              shift_d;
  logic [ADDR_W-1:0] addr_d;
  logic [3:0]        sh_msb;
  logic [3:0]        sh_lsb;

  function automatic logic [CNT_W-1:0] last_nib(input qspi_state_e s);
    case (s)
      ST_CMD:   last_nib = CNT_W'(CMD_NIBBLES - 1);
      ST_ADDR:  last_nib = CNT_W'(ADDR_NIBBLES - 1);
      ST_DUMMY: last_nib = CNT_W'(DUMMY_NIBBLES - 1);
      ST_DATA:  last_nib = CNT_W'(DATA_NIBBLES - 1);
      default:  last_nib = '0;
    endcase
  endfunction

  always_comb begin
    start_d = 1'b0;
    shift_d = 1'b0;
    addr_d  = req0 ? addr0 : addr1;
    if (state_q == ST_IDLE) begin
      start_d = req0 || req1;
    end
    // Shift at the close of phase B, the same edge that samples spi_io_in.
    if (ph_q && (state_q == ST_CMD || state_q == ST_ADDR || state_q == ST_DATA)) begin
      shift_d = 1'b1;
    end
  end

  qspi_nibble_shifter #(
    .W(SH_W)
  ) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (start_d),
    .load_val_i ({CMD, addr_d}),
    .shift_i    (shift_d),
    .nib_i      (spi_io_in),
    .msb_nib_o  (sh_msb),
    .lsb_nib_o  (sh_lsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ph_q     <= 1'b0;
      cnt_q    <= '0;
      grant1_q <= 1'b0;
      cs_n_q   <= 1'b1;
      sck_q    <= 1'b0;
      oe_q     <= 4'h0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata_q  <= 8'h00;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start_d) begin
            state_q  <= ST_CMD;
            grant1_q <= !req0;
            cs_n_q   <= 1'b0;
            sck_q    <= 1'b0;
            ph_q     <= 1'b0;
            cnt_q    <= '0;
            oe_q     <= 4'hF;
          end
        end
        ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
          if (!ph_q) begin
            ph_q  <= 1'b1;
            sck_q <= 1'b1;
          end else begin
            ph_q  <= 1'b0;
            sck_q <= 1'b0;
            if (cnt_q != last_nib(state_q)) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end else begin
              cnt_q <= '0;
              case (state_q)
                ST_CMD: state_q <= ST_ADDR;
                ST_ADDR: begin
                  state_q <= ST_DUMMY;
                  oe_q    <= 4'h0;
                end
                ST_DUMMY: state_q <= ST_DATA;
                default: begin
                  // Low data nibble arrives on this very edge, so it bypasses the shifter.
                  state_q <= ST_DESELECT;
                  cs_n_q  <= 1'b1;
                  ack0_q  <= !grant1_q;
                  ack1_q  <= grant1_q;
                  rdata_q <= {sh_lsb, spi_io_in};
                end
              endcase
            end
          end
        end
        ST_DESELECT: begin
          if (!ph_q) begin
            ph_q <= 1'b1;
          end else begin
            ph_q    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ph_q    <= 1'b0;
          cs_n_q  <= 1'b1;
          sck_q   <= 1'b0;
          oe_q    <= 4'h0;
        end
      endcase
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rdata       = rdata_q;
  assign busy        = (state_q != ST_IDLE);
  assign spi_sck     = sck_q;
  assign spi_cs_n    = cs_n_q;
  assign spi_io_oe   = oe_q;
  assign spi_io_out  = sh_msb & oe_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_qspi_rom_arbiter.sv
// Bench for qspi_rom_arbiter: a flash model answers on the bus, and acks, bus
// nibbles and chip-select gaps are compared with timing derived from the frame rules.
module tb_qspi_rom_arbiter;
  import qspi_pkg::*;

  localparam int         ADDR_W  = 24;
  localparam int         DUMMY   = 4;
  localparam logic [7:0] CMD_OP  = 8'hEB;
  localparam int         NIBS    = 2 + ADDR_W / 4 + DUMMY + 2;
  localparam int         LAT     = 1 + 2 * NIBS;     // grant cycle to ack cycle
  localparam int         PERIOD  = LAT + 2;          // grant cycle to earliest next grant
  localparam int         DATA0   = NIBS - 2;         // index of the high data nibble
  localparam int         CS_GAP  = PERIOD - LAT + 1; // two DESELECT cycles plus the regrant IDLE cycle
  localparam int         DUMMY_B = 8;
  localparam int         LAT_B   = 1 + 2 * (2 + ADDR_W / 4 + DUMMY_B + 2);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic              req0, req1, ack0, ack1, busy, spi_sck, spi_cs_n;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [7:0]        rdata;
  logic [3:0]        spi_io_out, spi_io_oe, spi_io_in;
  qspi_state_e       dbg_state;

  logic              req0_b, req1_b, ack0_b, ack1_b, busy_b, sck_b, cs_n_b;
  logic [ADDR_W-1:0] addr0_b, addr1_b;
  logic [7:0]        rdata_b;
  logic [3:0]        io_out_b, io_oe_b, io_in_b;
  qspi_state_e       dbg_state_b;

  qspi_rom_arbiter #(.ADDR_W(ADDR_W), .DUMMY_NIBBLES(DUMMY), .CMD(CMD_OP)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .ack1(ack1),
    .rdata(rdata), .busy(busy),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
    .spi_io_out(spi_io_out), .spi_io_oe(spi_io_oe), .spi_io_in(spi_io_in),
    .dbg_state_o(dbg_state)
  );

  qspi_rom_arbiter #(.ADDR_W(ADDR_W), .DUMMY_NIBBLES(DUMMY_B), .CMD(CMD_OP)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0(req0_b), .addr0(addr0_b), .ack0(ack0_b),
    .req1(req1_b), .addr1(addr1_b), .ack1(ack1_b),
    .rdata(rdata_b), .busy(busy_b),
    .spi_sck(sck_b), .spi_cs_n(cs_n_b),
    .spi_io_out(io_out_b), .spi_io_oe(io_oe_b), .spi_io_in(io_in_b),
    .dbg_state_o(dbg_state_b)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic        hold0 = 1'b0;
  logic        hold1 = 1'b0;
  logic [41:0] exp_q[$];      // {ack id, rdata, ack cycle}
  int          ack_cyc_q[$];
  int          ack_id_q[$];
  logic [7:0]  ack_dat_q[$];
  logic [7:0]  flash_q[$];    // bytes the flash returns, one per frame
  logic [3:0]  cap_nib_q[$];
  logic [3:0]  cap_oe_q[$];
  int          gap_q[$];

  // ---------------- flash model and bus monitor ----------------
  initial begin
    int         nib;
    int         hi_run;
    logic       prev_cs;
    logic [7:0] cur;
    nib = 0; hi_run = 0; prev_cs = 1'b1; cur = 8'h00;
    spi_io_in = 4'h0;
    forever begin
      @(negedge clk);
      if (ack0 || ack1) begin
        ack_cyc_q.push_back(cyc);
        ack_id_q.push_back((ack0 && ack1) ? 3 : (ack1 ? 1 : 0));
        ack_dat_q.push_back(rdata);
      end
      if (spi_cs_n) begin
        nib = 0;
        hi_run++;
      end else begin
        if (prev_cs) begin
          cur = (flash_q.size() > 0) ? flash_q.pop_front() : 8'h00;
          gap_q.push_back(hi_run);
        end
        hi_run = 0;
        if (spi_sck) begin
          cap_nib_q.push_back(spi_io_out);
          cap_oe_q.push_back(spi_io_oe);
          nib++;
        end
      end
      if (!spi_cs_n && !spi_sck) begin
        if (nib == DATA0)          spi_io_in = cur[7:4];
        else if (nib == DATA0 + 1) spi_io_in = cur[3:0];
        else                       spi_io_in = 4'($urandom);
      end else if (spi_cs_n) begin
        spi_io_in = 4'($urandom);
      end
      prev_cs = spi_cs_n;
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; requesters release their request on seeing their ack.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (ack0 && !hold0) req0 = 1'b0;
      if (ack1 && !hold1) req1 = 1'b0;
    end
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step(1);
  endtask

  task automatic wait_acks(input string tag, input int n, input int budget);
    int b;
    b = budget;
    while (ack_cyc_q.size() < n && b > 0) begin
      step(1);
      b--;
    end
    chk({tag, "_ack_count"}, 32'(ack_cyc_q.size()), 32'(n));
  endtask

  task automatic score(input string tag);
    logic [41:0] e;
    e = exp_q.pop_front();
    if (ack_cyc_q.size() == 0) begin
      chk({tag, "_ack_missing"}, 32'(ack_cyc_q.size()), 32'd1);
    end else begin
      chk({tag, "_ack_id"}, 32'(ack_id_q.pop_front()), 32'(e[41:40]));
      chk({tag, "_rdata"}, 32'(ack_dat_q.pop_front()), 32'(e[39:32]));
      chk({tag, "_ack_cycle"}, 32'(ack_cyc_q.pop_front()), e[31:0]);
    end
  endtask

  // Reference bus content for nibble i of a frame: {oe, io_out}.
  function automatic logic [7:0] exp_bus(input logic [ADDR_W-1:0] a, input int i);
    logic [ADDR_W+7:0] word;
    word = {CMD_OP, a};
    if (i < 2 + ADDR_W / 4) return {4'hF, 4'(word >> (ADDR_W + 4 - 4 * i))};
    return 8'h00;
  endfunction

  task automatic check_frame(input string tag, input logic [ADDR_W-1:0] a);
    logic [7:0] got;
    if (cap_nib_q.size() < NIBS) begin
      chk({tag, "_frame_len"}, 32'(cap_nib_q.size()), 32'(NIBS));
      cap_nib_q.delete();
      cap_oe_q.delete();
    end else begin
      for (int i = 0; i < NIBS; i++) begin
        got = {cap_oe_q.pop_front(), cap_nib_q.pop_front()};
        chk($sformatf("%s_nib%0d", tag, i), 32'(got), 32'(exp_bus(a, i)));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed and random steps ----------------
  initial begin
    logic [ADDR_W-1:0] a0, a1;
    logic [7:0]        d0, d1;
    logic [3:0]        b_nib;
    logic [7:0]        b_data;
    int                n, mode, nexp, last_ack, ack_at, bad_oe, nb1, nacks;

    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    req0_b = 1'b0; req1_b = 1'b0; addr0_b = '0; addr1_b = '0; io_in_b = 4'h0;

    // Reset values
    step(3);
    chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("rst_sck", 32'(spi_sck), 32'd0);
    chk("rst_oe", 32'(spi_io_oe), 32'd0);
    chk("rst_io_out", 32'(spi_io_out), 32'd0);
    chk("rst_acks", 32'({ack0, ack1}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    chk("idle_cs_n", 32'(spi_cs_n), 32'd1);

    // Single req0 at 001234 returning A5; address changes at N+3 are ignored
    a0 = 24'h001234;
    flash_q.push_back(8'hA5);
    n = cyc; addr0 = a0; req0 = 1'b1;
    exp_q.push_back({2'd0, 8'hA5, 32'(n + LAT)});
    step(1);
    chk("s1_cs_low_n1", 32'(spi_cs_n), 32'd0);
    chk("s1_busy", 32'(busy), 32'd1);
    step_to(n + 3);
    addr0 = 24'hFFFFFF;
    wait_acks("s1", 1, 2 * PERIOD);
    score("s1");
    check_frame("s1", a0);
    step_to(n + LAT + 1);
    chk("s1_desel_cs", 32'({spi_cs_n, spi_sck, busy}), 32'b101);
    step(1);
    chk("s1_idle_busy", 32'(busy), 32'd0);
    step(2);

    // Simultaneous requests: req0 first, req1 regranted one period later
    a0 = 24'($urandom); a1 = 24'($urandom); d0 = 8'($urandom); d1 = 8'($urandom);
    flash_q.push_back(d0); flash_q.push_back(d1);
    n = cyc; addr0 = a0; addr1 = a1; req0 = 1'b1; req1 = 1'b1;
    exp_q.push_back({2'd0, d0, 32'(n + LAT)});
    exp_q.push_back({2'd1, d1, 32'(n + PERIOD + LAT)});
    wait_acks("s2", 2, 3 * PERIOD);
    score("s2a");
    score("s2b");
    check_frame("s2a", a0);
    check_frame("s2b", a1);
    step_to(n + PERIOD + LAT + 3);

    // req1 held high: three back-to-back frames
    a1 = 24'($urandom);
    gap_q.delete();
    n = cyc; addr1 = a1; hold1 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d1 = 8'($urandom);
      flash_q.push_back(d1);
      exp_q.push_back({2'd1, d1, 32'(n + k * PERIOD + LAT)});
    end
    wait_acks("s3", 3, 4 * PERIOD);
    req1 = 1'b0; hold1 = 1'b0;
    for (int k = 0; k < 3; k++) score($sformatf("s3_%0d", k));
    for (int k = 0; k < 3; k++) check_frame($sformatf("s3f%0d", k), a1);
    chk("s3_gap_count", 32'(gap_q.size()), 32'd3);
    if (gap_q.size() == 3) begin
      chk("s3_gap1", 32'(gap_q[1]), 32'(CS_GAP));
      chk("s3_gap2", 32'(gap_q[2]), 32'(CS_GAP));
    end
    step_to(n + 2 * PERIOD + LAT + 3);

    // Grantee drops req1 and changes addr1 mid-frame
    a1 = 24'($urandom); d1 = 8'($urandom);
    flash_q.push_back(d1);
    n = cyc; addr1 = a1; req1 = 1'b1;
    exp_q.push_back({2'd1, d1, 32'(n + LAT)});
    step_to(n + 5);
    req1 = 1'b0; addr1 = ~a1;
    wait_acks("s4", 1, 2 * PERIOD);
    score("s4");
    check_frame("s4", a1);
    step_to(n + LAT + 3);

    // Reset at N+10: select drops immediately, no ack, next frame restarts
    a0 = 24'($urandom);
    flash_q.push_back(8'h3C);
    n = cyc; addr0 = a0; req0 = 1'b1;
    step_to(n + 10);
    rst_n = 1'b0;
    #1;
    chk("s5_rst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("s5_rst_oe", 32'(spi_io_oe), 32'd0);
    chk("s5_rst_sck", 32'(spi_sck), 32'd0);
    chk("s5_rst_busy", 32'(busy), 32'd0);
    req0 = 1'b0;
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
    step(LAT + 5);
    chk("s5_no_ack", 32'(ack_cyc_q.size()), 32'd0);
    flash_q.delete(); cap_nib_q.delete(); cap_oe_q.delete();
    a0 = 24'($urandom); d0 = 8'($urandom);
    flash_q.push_back(d0);
    n = cyc; addr0 = a0; req0 = 1'b1;
    exp_q.push_back({2'd0, d0, 32'(n + LAT)});
    wait_acks("s5", 1, 2 * PERIOD);
    score("s5");
    check_frame("s5", a0);
    step_to(n + LAT + 3);

    // Random request mixes against the timing model
    for (int it = 0; it < 8; it++) begin
      mode = $urandom_range(0, 2);
      a0 = 24'($urandom); a1 = 24'($urandom); d0 = 8'($urandom); d1 = 8'($urandom);
      n = cyc; addr0 = a0; addr1 = a1;
      if (mode == 0) begin
        flash_q.push_back(d0);
        exp_q.push_back({2'd0, d0, 32'(n + LAT)});
        nexp = 1; last_ack = n + LAT; req0 = 1'b1;
      end else if (mode == 1) begin
        flash_q.push_back(d1);
        exp_q.push_back({2'd1, d1, 32'(n + LAT)});
        nexp = 1; last_ack = n + LAT; req1 = 1'b1;
      end else begin
        flash_q.push_back(d0); flash_q.push_back(d1);
        exp_q.push_back({2'd0, d0, 32'(n + LAT)});
        exp_q.push_back({2'd1, d1, 32'(n + PERIOD + LAT)});
        nexp = 2; last_ack = n + PERIOD + LAT; req0 = 1'b1; req1 = 1'b1;
      end
      wait_acks($sformatf("rnd%0d", it), nexp, (nexp + 1) * PERIOD);
      for (int k = 0; k < nexp; k++) score($sformatf("rnd%0d_%0d", it, k));
      if (mode != 1) check_frame($sformatf("rnd%0da", it), a0);
      if (mode != 0) check_frame($sformatf("rnd%0db", it), a1);
      step_to(last_ack + 2);
      step($urandom_range(0, 3));
    end

    // Eight dummy nibbles: later ack, bus released through the whole dummy phase
    b_nib = 4'($urandom_range(1, 15));
    io_in_b = b_nib;
    addr0_b = 24'($urandom);
    bad_oe = 0; ack_at = -1; nb1 = 0; b_data = 8'h00; nacks = 0;
    n = cyc; req0_b = 1'b1;
    for (int k = 1; k <= LAT_B + 4; k++) begin
      step(1);
      if (k <= 2 + ADDR_W / 4 * 2 + 2 && io_oe_b !== 4'hF) bad_oe++;
      if (k > 2 * (2 + ADDR_W / 4) && k <= 2 * (2 + ADDR_W / 4 + DUMMY_B) && io_oe_b !== 4'h0) bad_oe++;
      if (ack1_b) nb1++;
      if (ack0_b) begin
        nacks++;
        if (ack_at < 0) begin
          ack_at = cyc; b_data = rdata_b; req0_b = 1'b0;
        end
      end
    end
    chk("b_ack_cycle", 32'(ack_at), 32'(n + LAT_B));
    chk("b_rdata", 32'(b_data), 32'({b_nib, b_nib}));
    chk("b_oe_window", 32'(bad_oe), 32'd0);
    chk("b_ack1_never", 32'(nb1), 32'd0);
    chk("b_single_ack", 32'(nacks), 32'd1);

    chk("no_stray_acks", 32'(ack_cyc_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
